// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. A clock-enable
//                divider produces the pixel tick; x/y counters, the valid
//                window, line/frame strobes, the frame counter and the sync
//                outputs all update on that tick. Sync outputs can be
//                delayed by PIPE_DLY ticks to line up with a downstream
//                pixel pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_AV       = 640,
    parameter int H_FP       = 16,
    parameter int H_SP       = 96,
    parameter int H_BP       = 48,
    parameter int V_AV       = 480,
    parameter int V_FP       = 10,
    parameter int V_SP       = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 1,
    parameter int PIPE_DLY   = 0,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pixEn,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          valid,
    output logic          hSync,
    output logic          vSync,
    output logic          lineStart,
    output logic          frameStart,
    output logic [7:0]    frameCount
);

    localparam int c_H_TOT = H_AV + H_FP + H_SP + H_BP;
    localparam int c_V_TOT = V_AV + V_FP + V_SP + V_BP;

    // Counter limits and decode boundaries, all held at CW bits.
    localparam logic [CW-1:0] c_H_LAST    = CW'(c_H_TOT - 1);
    localparam logic [CW-1:0] c_V_LAST    = CW'(c_V_TOT - 1);
    localparam logic [CW-1:0] c_H_AV      = CW'(H_AV);
    localparam logic [CW-1:0] c_V_AV      = CW'(V_AV);
    localparam logic [CW-1:0] c_HS_FIRST  = CW'(H_AV + H_FP);
    localparam logic [CW-1:0] c_HS_LAST   = CW'(H_AV + H_FP + H_SP - 1);
    localparam logic [CW-1:0] c_VS_FIRST  = CW'(V_AV + V_FP);
    localparam logic [CW-1:0] c_VS_LAST   = CW'(V_AV + V_FP + V_SP - 1);

    // Sync levels.
    localparam logic c_H_ACT  = (H_SYNC_POL != 0);
    localparam logic c_H_IDLE = (H_SYNC_POL == 0);
    localparam logic c_V_ACT  = (V_SYNC_POL != 0);
    localparam logic c_V_IDLE = (V_SYNC_POL == 0);

    // Divider sizing; a one-bit counter that never leaves 0 when CLK_DIV==1.
    localparam int                c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_pix_en;
    logic [CW-1:0]      r_x;
    logic [CW-1:0]      r_y;
    logic               r_valid;
    logic               r_line_start;
    logic               r_frame_start;
    logic [7:0]         r_frame_cnt;
    // Index 0 holds the raw sync for the current x/y; index k lags it k ticks.
    logic               r_hs_sr [0:PIPE_DLY];
    logic               r_vs_sr [0:PIPE_DLY];

    logic               w_tick;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic [CW-1:0]      w_x_nxt;
    logic [CW-1:0]      w_y_nxt;
    logic               w_valid_nxt;
    logic               w_hs_nxt;
    logic               w_vs_nxt;

    // Pixel tick: last enabled clk of each divider period.
    assign w_tick = en && (r_div == c_DIV_LAST);

    // Next raster position and everything decoded from it, so registered
    // outputs change on the same edge as x/y.
    always_comb begin
        w_x_wrap    = (r_x == c_H_LAST);
        w_y_wrap    = (r_y == c_V_LAST);
        w_x_nxt     = w_x_wrap ? '0 : r_x + 1'b1;
        w_y_nxt     = r_y;
        if (w_x_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + 1'b1;
        end
        w_valid_nxt = (w_x_nxt < c_H_AV) && (w_y_nxt < c_V_AV);
        w_hs_nxt    = ((w_x_nxt >= c_HS_FIRST) && (w_x_nxt <= c_HS_LAST)) ? c_H_ACT : c_H_IDLE;
        w_vs_nxt    = ((w_y_nxt >= c_VS_FIRST) && (w_y_nxt <= c_VS_LAST)) ? c_V_ACT : c_V_IDLE;
    end

    // Clock-enable divider, frozen while en is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    // Registered pixel strobe, high for the clk in which the new x/y appear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= w_tick;
        end
    end

    // Raster counters and valid window; reset parks at the last position so
    // the first tick lands on (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x     <= c_H_LAST;
            r_y     <= c_V_LAST;
            r_valid <= 1'b0;
        end else if (w_tick) begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // One-clk line/frame strobes; cleared on every non-tick clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_tick && (w_x_nxt == '0);
            r_frame_start <= w_tick && (w_x_nxt == '0) && (w_y_nxt == '0);
        end
    end

    // Frame counter, bumped together with frameStart, wraps mod 256.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_tick && (w_x_nxt == '0) && (w_y_nxt == '0)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    // Sync shift registers: raw sync enters stage 0, shifts only on ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= PIPE_DLY; i++) begin
                r_hs_sr[i] <= c_H_IDLE;
                r_vs_sr[i] <= c_V_IDLE;
            end
        end else if (w_tick) begin
            r_hs_sr[0] <= w_hs_nxt;
            r_vs_sr[0] <= w_vs_nxt;
            for (int i = 1; i <= PIPE_DLY; i++) begin
                r_hs_sr[i] <= r_hs_sr[i-1];
                r_vs_sr[i] <= r_vs_sr[i-1];
            end
        end
    end

    assign pixEn      = r_pix_en;
    assign x          = r_x;
    assign y          = r_y;
    assign valid      = r_valid;
    assign lineStart  = r_line_start;
    assign frameStart = r_frame_start;
    assign frameCount = r_frame_cnt;
    assign hSync      = r_hs_sr[PIPE_DLY];
    assign vSync      = r_vs_sr[PIPE_DLY];

endmodule
`default_nettype wire
